// File: rtl/limn2600_mem_master.sv
// Limn2600 load/store bus initiator: turns core requests into single-cycle SRAM strobes,
// handles byte/halfword lanes and performs read-modify-write for sub-word stores.
module limn2600_mem_master #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_RWAIT = 3'd2;
   localparam logic [2:0] S_WR    = 3'd3;
   localparam logic [2:0] S_WWAIT = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             we_q;
   logic [1:0]       size_q;
   logic [1:0]       lane_q;
   logic [15:0]      wdata_q;

   logic             illegal;
   logic             timed_out;
   logic [31:0]      load_data;
   logic [31:0]      merged;

   assign req_ready = (state == S_IDLE) && rst;

   always_comb begin
      illegal = 1'b0;
      case (req_size)
         2'b01:   illegal = req_addr[0];
         2'b10:   illegal = |req_addr[1:0];
         2'b11:   illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

   // The wait cycle being evaluated is the TIMEOUT-th one without rdy.
   assign timed_out = !mem_rdy && (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      load_data = mem_rdata;
      case (size_q)
         2'b00:   load_data = (mem_rdata >> {lane_q, 3'b000}) & 32'h0000_00FF;
         2'b01:   load_data = lane_q[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      merged = mem_rdata;
      if (size_q == 2'b00)
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the
   // sensitivity list, and all state uses non-blocking assignments so every register sees
   // the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         lane_q    <= 2'b00;
         wdata_q   <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         // Strobes default low so cs and rsp_valid can only ever be one-cycle pulses.
         mem_cs    <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  lane_q    <= req_addr[1:0];
                  wdata_q   <= req_wdata[15:0];
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
                  if (illegal) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && req_size == 2'b10) begin
                     state     <= S_WR;
                     mem_cs    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     state  <= S_RD;
                     mem_cs <= 1'b1;
                     mem_we <= 1'b0;
                  end
               end
            end
            S_RD: begin
               state    <= S_RWAIT;
               wait_cnt <= '0;
            end
            S_RWAIT: begin
               if (mem_rdy) begin
                  if (we_q) begin
                     state     <= S_WR;
                     mem_cs    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_wdata <= merged;
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_data;
                  end
               end else if (timed_out) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WR: begin
               state    <= S_WWAIT;
               wait_cnt <= '0;
            end
            S_WWAIT: begin
               if (mem_rdy) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
               end else if (timed_out) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_limn2600_mem_master.sv
// Scoreboard bench for limn2600_mem_master: stimulus pushes expected SRAM strobes and
// responses into queues; monitors pop and compare whenever the DUT presents them.
module tb_limn2600_mem_master;

   localparam int TIMEOUT = 15;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;
   localparam int M_NORMAL = 0;
   localparam int M_STALE  = 1;
   localparam int M_MUTE   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rdy = 1'b0;
   logic [31:0] mem_rdata = '0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } cs_t;

   rsp_t rsp_q[$];
   cs_t  cs_q[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mode = M_NORMAL;
   int last_rsp_cyc = 0;
   int last_accept = 0;

   limn2600_mem_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdy   (mem_rdy),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // SRAM responder: samples cs mid-cycle, answers with rdy one cycle after the cs edge.
   initial begin : responder
      logic [31:0] sram [0:63];
      logic        cs_seen;
      logic        we_seen;
      logic [5:0]  idx_seen;
      logic [31:0] wd_seen;
      for (int i = 0; i < 64; i++) sram[i] = '0;
      forever begin
         @(negedge clk);
         cs_seen  = mem_cs;
         we_seen  = mem_we;
         idx_seen = mem_addr[7:2];
         wd_seen  = mem_wdata;
         @(posedge clk);
         #1;
         if (mode == M_STALE)     mem_rdy = 1'b1;
         else if (mode == M_MUTE) mem_rdy = 1'b0;
         else                     mem_rdy = cs_seen;
         if (cs_seen) begin
            if (mode == M_MUTE)  mem_rdata = 32'hBAD0_BAD0;
            else if (we_seen)    sram[idx_seen] = wd_seen;
            else                 mem_rdata = sram[idx_seen];
         end
      end
   end

   always @(negedge clk) begin : monitor
      rsp_t r;
      cs_t  c;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) flag("unexpected rsp_valid");
         else begin
            r = rsp_q.pop_front();
            check("rsp_rdata", rsp_rdata, r.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            check("rsp_cycle", cyc, r.cyc);
            last_rsp_cyc = cyc;
         end
      end
      if (mem_cs) begin
         if (cs_q.size() == 0) flag("unexpected mem_cs");
         else begin
            c = cs_q.pop_front();
            check("cs_we", {31'd0, mem_we}, {31'd0, c.we});
            check("cs_addr", mem_addr, c.addr);
            if (c.we) check("cs_wdata", mem_wdata, c.wdata);
            check("cs_cycle", cyc, c.cyc);
         end
      end
   end

   // Called at (or just after) a negedge; returns at the negedge of response cycle 1.
   task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_rsp, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input bit rd_cs, input bit wr_cs,
                        input int wr_off, input logic [31:0] wr_word);
      int n = 0;
      int t;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         flag("req_ready never rose");
         return;
      end
      t = cyc + 1;
      last_accept = t;
      if (exp_rsp) rsp_q.push_back('{exp_rdata, exp_err, t + lat - 1});
      if (rd_cs) cs_q.push_back('{1'b0, {addr[31:2], 2'b00}, 32'd0, t});
      if (wr_cs) cs_q.push_back('{1'b1, {addr[31:2], 2'b00}, wr_word, t + wr_off});
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((rsp_q.size() != 0 || cs_q.size() != 0) && n < 100);
      if (rsp_q.size() != 0 || cs_q.size() != 0) begin
         flag("expected response or strobe never arrived");
         rsp_q.delete();
         cs_q.delete();
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = SZ_W;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset mem_cs", {31'd0, mem_cs}, 32'd0);
      check("reset mem_we", {31'd0, mem_we}, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset req_ready", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      #1;

      // word stores and load
      issue(1, SZ_W, 32'h20, 32'h1122_3344, 1, 32'h0, 0, 3, 0, 1, 0, 32'h1122_3344);
      wait_idle();
      issue(1, SZ_W, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 0, 3, 0, 1, 0, 32'hDEAD_BEEF);
      wait_idle();
      issue(0, SZ_W, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0, 3, 1, 0, 0, 32'h0);
      wait_idle();

      // byte RMW, then back-to-back byte load
      issue(1, SZ_B, 32'h22, 32'h0000_00AA, 1, 32'h0, 0, 5, 1, 1, 2, 32'h11AA_3344);
      wait_idle();
      issue(0, SZ_B, 32'h22, 32'h0, 1, 32'h0000_00AA, 0, 3, 1, 0, 0, 32'h0);
      check("back-to-back accept cycle", last_accept, last_rsp_cyc + 2);
      wait_idle();

      // lane extraction
      issue(0, SZ_H, 32'h22, 32'h0, 1, 32'h0000_11AA, 0, 3, 1, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_H, 32'h20, 32'h0, 1, 32'h0000_3344, 0, 3, 1, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_B, 32'h23, 32'h0, 1, 32'h0000_0011, 0, 3, 1, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_B, 32'h21, 32'h0, 1, 32'h0000_0033, 0, 3, 1, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_B, 32'h20, 32'h0, 1, 32'h0000_0044, 0, 3, 1, 0, 0, 32'h0); wait_idle();

      // illegal requests: error, no strobe, response in cycle 1
      issue(0, SZ_H, 32'h21, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_W, 32'h12, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0); wait_idle();
      issue(0, SZ_X, 32'h20, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0); wait_idle();
      issue(1, SZ_H, 32'h23, 32'hFFFF, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0); wait_idle();
      issue(1, SZ_W, 32'h11, 32'h1234_5678, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0); wait_idle();

      // halfword and byte RMW ignore the upper store-data bits
      issue(1, SZ_H, 32'h12, 32'h1234_CAFE, 1, 32'h0, 0, 5, 1, 1, 2, 32'hCAFE_BEEF); wait_idle();
      issue(1, SZ_B, 32'h11, 32'hFFFF_FF77, 1, 32'h0, 0, 5, 1, 1, 2, 32'hCAFE_77EF); wait_idle();
      issue(0, SZ_W, 32'h10, 32'h0, 1, 32'hCAFE_77EF, 0, 3, 1, 0, 0, 32'h0); wait_idle();

      // stale rdy held high: full sequence and latency unchanged
      mode = M_STALE;
      issue(0, SZ_W, 32'h20, 32'h0, 1, 32'h11AA_3344, 0, 3, 1, 0, 0, 32'h0); wait_idle();
      issue(1, SZ_B, 32'h23, 32'h55, 1, 32'h0, 0, 5, 1, 1, 2, 32'h55AA_3344); wait_idle();
      issue(0, SZ_H, 32'h22, 32'h0, 1, 32'h0000_55AA, 0, 3, 1, 0, 0, 32'h0); wait_idle();

      // responder never answers: timeout error, and no write after a failed RMW read
      mode = M_MUTE;
      issue(0, SZ_W, 32'h10, 32'h0, 1, 32'h0, 1, TIMEOUT + 2, 1, 0, 0, 32'h0); wait_idle();
      issue(1, SZ_B, 32'h10, 32'h99, 1, 32'h0, 1, TIMEOUT + 2, 1, 0, 0, 32'h0); wait_idle();
      issue(1, SZ_W, 32'h10, 32'h1357_9BDF, 1, 32'h0, 1, TIMEOUT + 2, 0, 1, 0, 32'h1357_9BDF);
      wait_idle();

      // reset while in RWAIT aborts without a response
      issue(0, SZ_W, 32'h10, 32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("mid-reset mem_cs", {31'd0, mem_cs}, 32'd0);
         check("mid-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
         check("mid-reset req_ready", {31'd0, req_ready}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("post-reset req_ready", {31'd0, req_ready}, 32'd1);
      mode = M_NORMAL;
      issue(0, SZ_W, 32'h10, 32'h0, 1, 32'hCAFE_77EF, 0, 3, 1, 0, 0, 32'h0);
      wait_idle();
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
